rtc_tick_gen: RTL
=================

RTC_TICK_GEN -- requirements
Module: rtc_tick_gen

Interface
REQ-001 SHALL have parameter PSCR_WIDTH, default 20: width of the prescaler value and the live count.
REQ-002 SHALL have parameter PSCR_MIN, default 2: minimum legal prescaler value.
REQ-003 SHALL have port clk_i, input, 1: the single clock. All logic is in this domain.
REQ-004 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port en_i, input, 1: run enable. Level-sensitive, sampled every cycle.
REQ-006 SHALL have port pscr_i, input, PSCR_WIDTH: new prescaler value.
REQ-007 SHALL have port pscr_valid_i, input, 1: new-value request.
REQ-008 SHALL have port pscr_ready_o, output, 1: block can accept a new value.
REQ-009 SHALL have port done_o, output, 1: high when no reconfiguration is pending.
REQ-010 SHALL have port tick_o, output, 1: one-cycle tick enable for the downstream RTC counter.
REQ-011 SHALL have port div_o, output, PSCR_WIDTH: live down-count value.
REQ-012 SHALL have port pscr_o, output, PSCR_WIDTH: the prescaler value currently in effect.

Function
REQ-013 SHALL implement three states: IDLE (en_i=0), RUN (counting, nothing pending) and PEND (counting, new value waiting for the period boundary).
REQ-014 SHALL accept a new value only on the cycle where pscr_valid_i=1 and pscr_ready_o=1.
REQ-015 SHALL drive pscr_ready_o=1 in IDLE and RUN and pscr_ready_o=0 in PEND.
REQ-016 SHALL clamp an accepted value below PSCR_MIN to PSCR_MIN; this is an unsigned compare.
REQ-017 SHALL, in RUN/PEND, decrement div_q by 1 each cycle while div_q!=0.
REQ-018 SHALL, when div_q==0, assert tick_o for that cycle only and reload div_q with (effective pscr - 1) on the next edge.
REQ-019 SHALL produce a tick period of exactly pscr_o cycles.
REQ-020 SHALL hold div_q at pscr_o-1 in IDLE and keep tick_o=0 there.
REQ-021 SHALL apply a value accepted in IDLE on the next edge: pscr_o=new, div_q=new-1. The state stays IDLE.
REQ-022 SHALL handle a value accepted in RUN with div_q!=0 as follows: store it as pending and go to PEND. pscr_o is unchanged until the boundary.
REQ-023 SHALL, in PEND when div_q==0, assert tick_o, set pscr_o=pending, reload div_q=pending-1 and go to RUN.
REQ-024 SHALL treat a value accepted in RUN on the same cycle as div_q==0 as follows: assert tick_o, apply the value immediately (pscr_o=new, div_q=new-1) and stay in RUN.
REQ-025 SHALL, on IDLE->RUN (en_i rises), keep div_q unchanged. The first tick therefore occurs pscr_o cycles after the first cycle en_i is sampled high.
REQ-026 SHALL, when en_i falls in RUN, go to IDLE and set div_q=pscr_o-1. No tick occurs on that cycle.
REQ-027 SHALL, when en_i falls in PEND, apply the pending value immediately, go to IDLE and drop the pending request. No tick occurs.
REQ-028 SHALL drive done_o=1 in IDLE and RUN and done_o=0 in PEND.
REQ-029 SHALL make all outputs registered or decoded from state/div_q only. There is no combinational path from any input to any output.

Reset
REQ-030 SHALL, with rst_i=1 at a clk_i edge, set state=IDLE, pscr_o=PSCR_MIN, div_q=PSCR_MIN-1 and clear the pending value to 0.
REQ-031 SHALL hold tick_o=0, pscr_ready_o=1 and done_o=1 during and immediately after reset.
REQ-032 SHALL treat rst_i as overriding en_i and pscr_valid_i in the same cycle, including mid-period and in PEND. The pending value is discarded.

Verification
REQ-033 SHALL be verified for reset defaults: after reset with en_i=0 -> pscr_o=2, div_o=1, tick_o=0, pscr_ready_o=1, done_o=1.
REQ-034 SHALL be verified for clamp and period: in IDLE load pscr_i=0, then en_i=1 -> pscr_o=2 and tick_o every 2nd cycle. Load 5 in IDLE, then en_i=1 -> the first tick comes 5 cycles after en_i is sampled high, then every 5 cycles.
REQ-035 SHALL be verified for a mid-period reload: running with pscr_o=8, load 3 when div_o=5 -> done_o=0 and pscr_ready_o=0 for 5 cycles, a tick at div_o=0, then ticks every 3 cycles and done_o=1.
REQ-036 SHALL be verified for a boundary-coincident reload: running with pscr_o=4, load 6 on a div_o=0 cycle -> tick asserted that cycle, pscr_o=6 next cycle, done_o stays 1, next tick 6 cycles later.
REQ-037 SHALL be verified for disable in PEND: pscr_o=10, pending 4, en_i=0 -> next cycle IDLE, pscr_o=4, div_o=3, done_o=1, no tick.
REQ-038 SHALL be verified for reset mid-operation: rst_i=1 in PEND with div_o=7 -> next cycle pscr_o=2, div_o=1, IDLE, tick_o=0, pending value lost.

Source files
------------

// File: rtl/rtc_tick_gen.sv
// Prescaler tick generator for the RTC: divides clk_i down to a one-cycle tick.
// A new prescaler value takes effect only on a period boundary while counting.
module rtc_tick_gen #(
    parameter int PSCR_WIDTH = 20,
    parameter int PSCR_MIN   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [PSCR_WIDTH-1:0] pscr_i,
    input  logic                  pscr_valid_i,
    output logic                  pscr_ready_o,
    output logic                  done_o,
    output logic                  tick_o,
    output logic [PSCR_WIDTH-1:0] div_o,
    output logic [PSCR_WIDTH-1:0] pscr_o
);

    localparam logic [PSCR_WIDTH-1:0] MIN_V = PSCR_WIDTH'(PSCR_MIN);
    localparam logic [PSCR_WIDTH-1:0] ONE   = PSCR_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PSCR_WIDTH-1:0] pscr_q, pscr_d;
    logic [PSCR_WIDTH-1:0] pend_q, pend_d;
    logic [PSCR_WIDTH-1:0] div_q, div_d;

    logic                  accept;
    logic                  div_zero;
    logic [PSCR_WIDTH-1:0] new_v;

    assign accept   = pscr_valid_i && (state_q != PEND);
    assign div_zero = (div_q == '0);
    assign new_v    = (pscr_i < MIN_V) ? MIN_V : pscr_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pscr_q  <= MIN_V;
            pend_q  <= '0;
            div_q   <= MIN_V - ONE;
        end else begin
            state_q <= state_d;
            pscr_q  <= pscr_d;
            pend_q  <= pend_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pscr_d  = pscr_q;
        pend_d  = pend_q;
        div_d   = div_q;
        unique case (state_q)
            IDLE: begin
                // Count is parked at pscr-1 so enabling starts a full period.
                if (accept) begin
                    pscr_d = new_v;
                    div_d  = new_v - ONE;
                end else begin
                    div_d = pscr_q - ONE;
                end
                if (en_i) state_d = RUN;
            end
            RUN: begin
                if (!en_i) begin
                    state_d = IDLE;
                    pscr_d  = accept ? new_v : pscr_q;
                    div_d   = (accept ? new_v : pscr_q) - ONE;
                end else if (div_zero) begin
                    pscr_d = accept ? new_v : pscr_q;
                    div_d  = (accept ? new_v : pscr_q) - ONE;
                end else begin
                    div_d = div_q - ONE;
                    if (accept) begin
                        pend_d  = new_v;
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (!en_i || div_zero) begin
                    pscr_d  = pend_q;
                    div_d   = pend_q - ONE;
                    pend_d  = '0;
                    state_d = en_i ? RUN : IDLE;
                end else begin
                    div_d = div_q - ONE;
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = pscr_q - ONE;
            end
        endcase
    end

    assign tick_o       = (state_q != IDLE) && div_zero;
    assign pscr_ready_o = (state_q != PEND);
    assign done_o       = (state_q != PEND);
    assign div_o        = div_q;
    assign pscr_o       = pscr_q;

endmodule
